pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Pipeline sequencer for the 5-stage core. It sits beside the instruction decoder and drives the pipeline-register enables, the `bubble` input of the decoder and the IF/ID flush. It resolves four conditions:
- load-use hazards
- data-memory wait handshakes
- EX-stage redirects (branch/jal/jalr)
- the halt drain sequence

It also keeps a saturating stall-cycle counter.

Parameters:
DRAIN_CYCLES, 3, cycles after an accepted halt before the core is reported halted (lets the EX/MEM/WB instructions retire); legal range 1..15
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_read_reg1  in  5  rs1 of the instruction in ID
id_read_reg2  in  5  rs2 of the instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch)
id_hlt  in  1  ID instruction is a halt
ex_valid  in  1  EX stage holds a real instruction
ex_mem_reg  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes a register
ex_write_reg  in  5  rd of the EX instruction
ex_redirect  in  1  EX resolved a taken branch, jal or jalr; PC mux selects the target
dmem_req  in  1  MEM stage has a data-memory access outstanding
dmem_ack  in  1  data memory completes the access this cycle
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID register load enable
flush_if_id  out  1  IF/ID register loads a NOP
bubble  out  1  to decoder; the ID instruction enters EX as a NOP
pipe_freeze  out  1  holds ID/EX, EX/MEM and MEM/WB registers
halted  out  1  core stopped
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0, excluding HALTED

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN, drain_cnt=0, stall_cycles=0.
  - While held in reset: pc_en=0, if_id_en=0, bubble=1, flush_if_id=0, pipe_freeze=0, halted=0.
  - The first cycle after release is normal RUN.
- Outputs are Mealy: combinational from the registered state and the current inputs. All state updates happen on the rising edge of clk.
- Load-use hazard (lu) is asserted when all of the following hold:
  - ex_valid, ex_mem_reg, ex_reg_write, id_valid
  - ex_write_reg != 0
  - ex_write_reg == id_read_reg1, or (id_uses_rs2 and ex_write_reg == id_read_reg2)
- Memory wait: mw = dmem_req & ~dmem_ack.
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Priority in RUN (highest first):
  1. mw: pipe_freeze=1, pc_en=0, if_id_en=0, bubble=0. Next state MEM_WAIT. Any redirect or lu is held and re-evaluated after the wait.
  2. ex_redirect: pc_en=1, if_id_en=1, flush_if_id=1, bubble=1. Stay RUN. A halt or lu in ID is squashed by this.
  3. lu: pc_en=0, if_id_en=0, bubble=1 for exactly one cycle; the load advances to MEM. Stay RUN.
  4. id_valid & id_hlt: pc_en=0, if_id_en=0, bubble=1. Load drain_cnt=DRAIN_CYCLES; next state DRAIN.
  5. Otherwise: pc_en=1, if_id_en=1, bubble=0, flush_if_id=0, pipe_freeze=0.
- MEM_WAIT:
  - Outputs are identical to RUN case 1 until dmem_ack=1.
  - On the cycle dmem_ack=1, outputs are computed as RUN with mw=0; next state RUN.
  - The return state is RUN even if the stall began in DRAIN; drain_cnt is retained, and DRAIN resumes if drain_cnt != 0.
- DRAIN:
  - pc_en=0, if_id_en=0, bubble=1.
  - drain_cnt decrements each cycle unless mw; mw sets pipe_freeze=1 and holds the counter.
  - ex_redirect in DRAIN comes from an older branch: the halt is cancelled. Apply flush_if_id=1, pc_en=1, if_id_en=1; clear drain_cnt; next state RUN.
  - drain_cnt reaching 1 with no mw: next state HALTED.
- HALTED:
  - halted=1, pc_en=0, if_id_en=0, bubble=1, pipe_freeze=1.
  - All inputs are ignored. The only exit is rst_n.
- stall_cycles:
  - Increments on every clock edge where pc_en=0 and state != HALTED.
  - Saturates at 2^CNT_W-1; no wrap.
- A halt in ID with lu simultaneously true: lu wins. The halt is accepted the next cycle.
- Register x0 never produces a hazard.

Decomposition:
- pipe_pkg holds:
  - the state enum (RUN, MEM_WAIT, DRAIN, HALTED; 2-bit encoding)
  - REG_ZERO=5'd0
- One sub-module, hazard_cmp: the combinational load-use comparator producing lu. The hazard unit for forwarding will reuse it later.

Test Plan:
1. Load x5 in EX, `add x6,x5,x1` in ID (rs1 matches) -> one cycle with pc_en=0, if_id_en=0, bubble=1; next cycle pc_en=1; stall_cycles=1.
2. Same load, ID reads x0 or an unrelated register, and a load to x0 with a matching rs -> no stall, pc_en=1 throughout.
3. dmem_req=1 with dmem_ack held low 4 cycles while ex_redirect=1 -> pipe_freeze=1 for 4 cycles with no flush; on the ack cycle flush_if_id=1, bubble=1, pc_en=1.
4. Halt in ID, no other events, DRAIN_CYCLES=3 -> three DRAIN cycles, then halted=1; stall_cycles stops at 4 (halt-accept cycle plus DRAIN); rst_n low clears all.
5. Halt accepted, then ex_redirect in the second DRAIN cycle -> flush_if_id=1, state RUN, halted never asserts.
6. rst_n asserted mid-MEM_WAIT -> outputs go to reset values immediately (asynchronously); after release, pc_en=1 in the first RUN cycle with no inputs asserted.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: FSM state, RUN-priority decision
// and the bundle of pipeline control outputs.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Which RUN rule wins this cycle, highest priority first.
  typedef enum logic [2:0] {
    RC_WAIT     = 3'd0,
    RC_REDIRECT = 3'd1,
    RC_RESUME   = 3'd2,
    RC_LU       = 3'd3,
    RC_HALT     = 3'd4,
    RC_GO       = 3'd5
  } run_case_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic flush_if_id;
    logic bubble;
    logic pipe_freeze;
    logic halted;
  } ctrl_t;

  // RC_RESUME: a drain interrupted by a memory wait picks up where it left off.
  function automatic run_case_t run_rule(input logic mw, input logic redirect,
                                         input logic draining, input logic lu,
                                         input logic halt_req);
    if (mw)       return RC_WAIT;
    if (redirect) return RC_REDIRECT;
    if (draining) return RC_RESUME;
    if (lu)       return RC_LU;
    if (halt_req) return RC_HALT;
    return RC_GO;
  endfunction

  function automatic ctrl_t run_ctrl(input run_case_t rc);
    ctrl_t c;
    c.pc_en       = 1'b0;
    c.if_id_en    = 1'b0;
    c.flush_if_id = 1'b0;
    c.bubble      = 1'b1;
    c.pipe_freeze = 1'b0;
    c.halted      = 1'b0;
    case (rc)
      RC_WAIT: begin
        c.bubble      = 1'b0;
        c.pipe_freeze = 1'b1;
      end
      RC_REDIRECT: begin
        c.pc_en       = 1'b1;
        c.if_id_en    = 1'b1;
        c.flush_if_id = 1'b1;
      end
      RC_GO: begin
        c.pc_en    = 1'b1;
        c.if_id_en = 1'b1;
        c.bubble   = 1'b0;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline sequencer (master) and the core datapath (slave).
// dmem_req is held by MEM while an access is outstanding; dmem_ack marks the
// single cycle it completes. A cycle with dmem_req=1 and dmem_ack=0 is a wait.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
) ();
  import pipe_pkg::*;

  logic             id_valid;
  logic [4:0]       id_read_reg1;
  logic [4:0]       id_read_reg2;
  logic             id_uses_rs2;
  logic             id_hlt;
  logic             ex_valid;
  logic             ex_mem_reg;
  logic             ex_reg_write;
  logic [4:0]       ex_write_reg;
  logic             ex_redirect;
  logic             dmem_req;
  logic             dmem_ack;
  logic             pc_en;
  logic             if_id_en;
  logic             flush_if_id;
  logic             bubble;
  logic             pipe_freeze;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  state_t           dbg_state;

  modport master (
    input  id_valid, id_read_reg1, id_read_reg2, id_uses_rs2, id_hlt,
    input  ex_valid, ex_mem_reg, ex_reg_write, ex_write_reg, ex_redirect,
    input  dmem_req, dmem_ack,
    output pc_en, if_id_en, flush_if_id, bubble, pipe_freeze, halted,
    output stall_cycles, dbg_state
  );

  modport slave (
    output id_valid, id_read_reg1, id_read_reg2, id_uses_rs2, id_hlt,
    output ex_valid, ex_mem_reg, ex_reg_write, ex_write_reg, ex_redirect,
    output dmem_req, dmem_ack,
    input  pc_en, if_id_en, flush_if_id, bubble, pipe_freeze, halted,
    input  stall_cycles, dbg_state
  );
endinterface

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Load-use comparator: a load in EX whose rd is read by the ID instruction.
// Kept standalone so the forwarding unit can share it.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_read_reg1,
  input  logic [4:0] id_read_reg2,
  input  logic       id_uses_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_reg,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_write_reg,
  output logic       lu
);
  logic rs1_hit;
  logic rs2_hit;
  logic load_live;

  assign load_live = ex_valid & ex_mem_reg & ex_reg_write & id_valid &
                     (ex_write_reg != REG_ZERO);
  assign rs1_hit   = (ex_write_reg == id_read_reg1);
  assign rs2_hit   = id_uses_rs2 & (ex_write_reg == id_read_reg2);
  assign lu        = load_live & (rs1_hit | rs2_hit);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stalls for load-use and data-memory waits, flushes on
// EX redirects, drains and stops the core on halt, counts stall cycles.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.master bus
);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       drain_cnt;
  logic [3:0]       drain_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lu;
  logic             mw;
  run_case_t        rc_run;
  run_case_t        rc_ack;
  ctrl_t            ctl;

  hazard_cmp u_hazard_cmp (
    .id_valid     (bus.id_valid),
    .id_read_reg1 (bus.id_read_reg1),
    .id_read_reg2 (bus.id_read_reg2),
    .id_uses_rs2  (bus.id_uses_rs2),
    .ex_valid     (bus.ex_valid),
    .ex_mem_reg   (bus.ex_mem_reg),
    .ex_reg_write (bus.ex_reg_write),
    .ex_write_reg (bus.ex_write_reg),
    .lu           (lu)
  );

  assign mw = bus.dmem_req & ~bus.dmem_ack;

  // rc_ack is the RUN decision on the cycle a memory wait completes.
  assign rc_run = run_rule(mw, bus.ex_redirect, drain_cnt != 4'd0, lu,
                           bus.id_valid & bus.id_hlt);
  assign rc_ack = run_rule(1'b0, bus.ex_redirect, drain_cnt != 4'd0, lu,
                           bus.id_valid & bus.id_hlt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    unique case (state)
      ST_RUN: begin
        case (rc_run)
          RC_WAIT:     state_nxt = ST_MEM_WAIT;
          RC_REDIRECT: drain_nxt = 4'd0;
          RC_RESUME:   state_nxt = ST_DRAIN;
          RC_HALT: begin
            drain_nxt = DRAIN_INIT;
            state_nxt = ST_DRAIN;
          end
          default: ;
        endcase
      end
      ST_MEM_WAIT: begin
        if (!mw) begin
          state_nxt = ST_RUN;
          if (rc_ack == RC_REDIRECT) drain_nxt = 4'd0;
        end
      end
      ST_DRAIN: begin
        if (mw) begin
          state_nxt = ST_MEM_WAIT;
        end else if (bus.ex_redirect) begin
          drain_nxt = 4'd0;
          state_nxt = ST_RUN;
        end else if (drain_cnt <= 4'd1) begin
          drain_nxt = 4'd0;
          state_nxt = ST_HALTED;
        end else begin
          drain_nxt = drain_cnt - 4'd1;
        end
      end
      ST_HALTED: ;
    endcase
  end

  // Reset forces the control outputs asynchronously, not just via the state.
  always_comb begin
    ctl = run_ctrl(RC_LU);
    if (rst_n) begin
      unique case (state)
        ST_RUN:      ctl = run_ctrl(rc_run);
        ST_MEM_WAIT: ctl = mw ? run_ctrl(RC_WAIT) : run_ctrl(rc_ack);
        ST_DRAIN: begin
          if (mw) begin
            ctl.pipe_freeze = 1'b1;
          end else if (bus.ex_redirect) begin
            ctl.pc_en       = 1'b1;
            ctl.if_id_en    = 1'b1;
            ctl.flush_if_id = 1'b1;
          end
        end
        ST_HALTED: begin
          ctl.halted      = 1'b1;
          ctl.pipe_freeze = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!ctl.pc_en && state != ST_HALTED && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.pc_en        = ctl.pc_en;
  assign bus.if_id_en     = ctl.if_id_en;
  assign bus.flush_if_id  = ctl.flush_if_id;
  assign bus.bubble       = ctl.bubble;
  assign bus.pipe_freeze  = ctl.pipe_freeze;
  assign bus.halted       = ctl.halted;
  assign bus.stall_cycles = stall_cnt;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, every cycle
// checked against a behavioural model through an expected-output queue.
module tb_pipe_ctrl;
  localparam int CNT_W   = 4;
  localparam int DRAIN   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int OUT_W   = 6 + CNT_W;

  typedef struct {
    bit       rst;
    bit       id_valid;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       uses_rs2;
    bit       hlt;
    bit       ex_valid;
    bit       ex_load;
    bit       ex_wr;
    bit [4:0] rd;
    bit       redirect;
    bit       req;
    bit       ack;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic [OUT_W-1:0] exp_q[$];

  // model: mode 0=running 1=waiting on memory 2=draining 3=stopped
  int m_mode  = 0;
  int m_drain = 0;
  int m_stall = 0;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, default: '0};
    return s;
  endfunction

  task automatic model_cycle(input stim_t s, output logic [OUT_W-1:0] e);
    bit pc, ife, fl, bub, frz, hlt, lu, mw, from_wait;
    int cur;
    pc = 0; ife = 0; fl = 0; bub = 1; frz = 0; hlt = 0;
    if (!s.rst) begin
      m_mode = 0; m_drain = 0; m_stall = 0;
      e = {pc, ife, fl, bub, frz, hlt, CNT_W'(0)};
      return;
    end
    cur = m_mode;
    e = '0;
    lu = s.ex_valid && s.ex_load && s.ex_wr && s.id_valid && s.rd != 0 &&
         (s.rd == s.rs1 || (s.uses_rs2 && s.rd == s.rs2));
    mw = s.req && !s.ack;
    if (cur == 3) begin
      hlt = 1; frz = 1;
    end else if (cur == 2) begin
      if (mw) begin
        frz = 1; m_mode = 1;
      end else if (s.redirect) begin
        pc = 1; ife = 1; fl = 1; m_drain = 0; m_mode = 0;
      end else begin
        if (m_drain == 1) m_mode = 3;
        m_drain = m_drain - 1;
      end
    end else if (cur == 1 && mw) begin
      bub = 0; frz = 1;
    end else begin
      from_wait = (cur == 1);
      m_mode = 0;
      if (mw) begin
        bub = 0; frz = 1; m_mode = 1;
      end else if (s.redirect) begin
        pc = 1; ife = 1; fl = 1; m_drain = 0;
      end else if (m_drain != 0) begin
        if (!from_wait) m_mode = 2;
      end else if (lu) begin
        // one-cycle bubble while the load moves on to MEM
      end else if (s.id_valid && s.hlt) begin
        if (!from_wait) begin
          m_drain = DRAIN; m_mode = 2;
        end
      end else begin
        pc = 1; ife = 1; bub = 0;
      end
    end
    e = {pc, ife, fl, bub, frz, hlt, CNT_W'(m_stall)};
    if (!pc && cur != 3 && m_stall < CNT_MAX) m_stall++;
  endtask

  task automatic apply(input stim_t s);
    logic [OUT_W-1:0] e;
    @(posedge clk);
    #1;
    rst_n            = s.rst;
    bus.id_valid     = s.id_valid;
    bus.id_read_reg1 = s.rs1;
    bus.id_read_reg2 = s.rs2;
    bus.id_uses_rs2  = s.uses_rs2;
    bus.id_hlt       = s.hlt;
    bus.ex_valid     = s.ex_valid;
    bus.ex_mem_reg   = s.ex_load;
    bus.ex_reg_write = s.ex_wr;
    bus.ex_write_reg = s.rd;
    bus.ex_redirect  = s.redirect;
    bus.dmem_req     = s.req;
    bus.dmem_ack     = s.ack;
    model_cycle(s, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    apply(s);
    apply(s);
  endtask

  // monitor: every cycle the DUT presents a full set of outputs
  initial begin
    logic [OUT_W-1:0] act, exp_v;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act = {bus.pc_en, bus.if_id_en, bus.flush_if_id, bus.bubble,
               bus.pipe_freeze, bus.halted, bus.stall_cycles};
        n_checks++;
        if (act !== exp_v) begin
          n_errors++;
          $display("FAIL cycle_outputs cyc=%0d act=%b exp=%b (pc,ifid,flush,bub,frz,hlt,cnt)",
                   cyc, act, exp_v);
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [5:0] rst_ctl;
    bus.id_valid = 0; bus.id_read_reg1 = 0; bus.id_read_reg2 = 0;
    bus.id_uses_rs2 = 0; bus.id_hlt = 0; bus.ex_valid = 0; bus.ex_mem_reg = 0;
    bus.ex_reg_write = 0; bus.ex_write_reg = 0; bus.ex_redirect = 0;
    bus.dmem_req = 0; bus.dmem_ack = 0;
    do_reset();

    // load x5 in EX, add x6,x5,x1 in ID
    s = idle();
    s.ex_valid = 1; s.ex_load = 1; s.ex_wr = 1; s.rd = 5;
    s.id_valid = 1; s.rs1 = 5; s.rs2 = 1; s.uses_rs2 = 1;
    apply(s);
    s.ex_valid = 0;
    apply(s);
    apply(idle());

    // no hazard: x0 / unrelated regs / load to x0
    s = idle();
    s.ex_valid = 1; s.ex_load = 1; s.ex_wr = 1; s.rd = 5; s.id_valid = 1;
    s.rs1 = 0; s.rs2 = 0; s.uses_rs2 = 1;
    apply(s);
    s.rs1 = 7; s.rs2 = 9;
    apply(s);
    s.rs1 = 5; s.uses_rs2 = 0; s.rs2 = 5; s.rs1 = 3;
    apply(s);
    s.rd = 0; s.rs1 = 0; s.rs2 = 0; s.uses_rs2 = 1;
    apply(s);
    do_reset();

    // memory wait with a pending redirect
    s = idle();
    s.req = 1; s.redirect = 1;
    for (int i = 0; i < 4; i++) apply(s);
    s.ack = 1;
    apply(s);
    apply(idle());
    do_reset();

    // halt drain to stop, then reset
    s = idle();
    s.id_valid = 1; s.hlt = 1;
    for (int i = 0; i < 7; i++) apply(s);
    do_reset();

    // halt cancelled by a redirect in the second drain cycle
    s = idle();
    s.id_valid = 1; s.hlt = 1;
    apply(s);
    apply(s);
    s.redirect = 1;
    apply(s);
    apply(idle());
    apply(idle());
    do_reset();

    // asynchronous reset in the middle of a memory wait
    s = idle();
    s.req = 1;
    apply(s);
    apply(s);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rst_ctl = {bus.pc_en, bus.if_id_en, bus.flush_if_id, bus.bubble,
               bus.pipe_freeze, bus.halted};
    n_checks++;
    if (rst_ctl !== 6'b000100) begin
      n_errors++;
      $display("FAIL async_reset_outputs act=%b exp=000100", rst_ctl);
    end
    n_checks++;
    if (bus.stall_cycles !== '0) begin
      n_errors++;
      $display("FAIL async_reset_count act=%0d exp=0", bus.stall_cycles);
    end
    s = idle();
    s.rst = 0; s.req = 1;
    apply(s);
    apply(idle());
    apply(idle());

    // random traffic, periodic reset so HALTED is always left again
    for (int n = 0; n < 800; n++) begin
      s = idle();
      s.rst      = (n % 60) != 59;
      s.id_valid = $urandom_range(0, 3) != 0;
      s.rs1      = 5'($urandom_range(0, 7));
      s.rs2      = 5'($urandom_range(0, 7));
      s.uses_rs2 = $urandom_range(0, 1) == 1;
      s.hlt      = $urandom_range(0, 9) == 0;
      s.ex_valid = $urandom_range(0, 1) == 1;
      s.ex_load  = $urandom_range(0, 1) == 1;
      s.ex_wr    = $urandom_range(0, 3) != 0;
      s.rd       = 5'($urandom_range(0, 7));
      s.redirect = $urandom_range(0, 7) == 0;
      s.req      = $urandom_range(0, 3) == 0;
      s.ack      = $urandom_range(0, 1) == 1;
      apply(s);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drained act=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
